// File: rtl/alu_seq_unit.sv
// Registered ALU execution unit with start/busy/done handshake.
// Single-cycle logic/arithmetic ops plus iterative SHL, SHR and shift-add MUL.
module alu_seq_unit #(
    parameter int DataWidth = 16,
    parameter int ShiftBits = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           FuncOp,
    input  logic [DataWidth-1:0] A,
    input  logic [DataWidth-1:0] B,
    input  logic                 FlagClr,
    output logic                 Busy,
    output logic                 Done,
    output logic [DataWidth-1:0] Y,
    output logic [3:0]           OFlags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int            CntW     = ShiftBits + 1;
    localparam logic [CntW-1:0] MulSteps = CntW'(DataWidth);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    // Flag word layout: {V, N, C, Z}
    function automatic logic [3:0] make_flags(input logic [DataWidth-1:0] r,
                                              input logic c, input logic v);
        return {v, r[DataWidth-1], c, (r == '0)};
    endfunction

    function automatic logic add_ovf(input logic signed [DataWidth-1:0] a,
                                     input logic signed [DataWidth-1:0] b,
                                     input logic signed [DataWidth-1:0] r);
        return (a[DataWidth-1] == b[DataWidth-1]) && (r[DataWidth-1] != a[DataWidth-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DataWidth-1:0] a,
                                     input logic signed [DataWidth-1:0] b,
                                     input logic signed [DataWidth-1:0] r);
        return (a[DataWidth-1] != b[DataWidth-1]) && (r[DataWidth-1] != a[DataWidth-1]);
    endfunction

    logic [1:0]           state_q;
    logic [3:0]           op_q;
    logic [DataWidth-1:0] acc_q;
    logic [DataWidth-1:0] hi_q;
    logic [DataWidth-1:0] mcand_q;
    logic [CntW-1:0]      cnt_q;

    logic [ShiftBits-1:0] shamt;
    logic                 go_exec;
    logic [DataWidth:0]   sum_w;
    logic [DataWidth:0]   dif_w;
    logic [DataWidth:0]   msum;

    assign shamt   = B[ShiftBits-1:0];
    assign go_exec = (((FuncOp == OP_SHL) || (FuncOp == OP_SHR)) && (shamt != '0))
                     || (FuncOp == OP_MUL);
    assign sum_w   = {1'b0, A} + {1'b0, B};
    assign dif_w   = {1'b0, A} - {1'b0, B};
    assign msum    = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    logic [DataWidth-1:0] one_y;
    logic [3:0]           one_f;
    logic                 one_wr_y;

    always_comb begin
        one_y    = '0;
        one_f    = 4'b0001;
        one_wr_y = 1'b1;
        case (FuncOp)
            OP_ADD: begin
                one_y = sum_w[DataWidth-1:0];
                one_f = make_flags(one_y, sum_w[DataWidth], add_ovf(A, B, one_y));
            end
            OP_SUB: begin
                one_y = dif_w[DataWidth-1:0];
                one_f = make_flags(one_y, dif_w[DataWidth], sub_ovf(A, B, one_y));
            end
            OP_AND: begin one_y = A & B; one_f = make_flags(one_y, 1'b0, 1'b0); end
            OP_OR:  begin one_y = A | B; one_f = make_flags(one_y, 1'b0, 1'b0); end
            OP_XOR: begin one_y = A ^ B; one_f = make_flags(one_y, 1'b0, 1'b0); end
            OP_NOT: begin one_y = ~A;    one_f = make_flags(one_y, 1'b0, 1'b0); end
            // Zero-length shifts complete immediately with the operand unchanged
            OP_SHL, OP_SHR: begin one_y = A; one_f = make_flags(A, 1'b0, 1'b0); end
            OP_MUL: one_wr_y = 1'b0;
            OP_CMP: begin
                one_wr_y = 1'b0;
                one_f    = make_flags(dif_w[DataWidth-1:0], dif_w[DataWidth],
                                      sub_ovf(A, B, dif_w[DataWidth-1:0]));
            end
            default: begin one_y = '0; one_f = 4'b0001; end
        endcase
    end

    logic [DataWidth-1:0] step_acc;
    logic [DataWidth-1:0] step_hi;
    logic                 step_c;

    // MUL keeps {hi_q, acc_q} as the running product with the multiplier in acc_q
    always_comb begin
        step_acc = acc_q;
        step_hi  = hi_q;
        step_c   = 1'b0;
        case (op_q)
            OP_SHL: begin step_acc = {acc_q[DataWidth-2:0], 1'b0}; step_c = acc_q[DataWidth-1]; end
            OP_SHR: begin step_acc = {1'b0, acc_q[DataWidth-1:1]}; step_c = acc_q[0]; end
            default: begin
                step_hi  = msum[DataWidth:1];
                step_acc = {msum[0], acc_q[DataWidth-1:1]};
                step_c   = |step_hi;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if ((state_q == ST_IDLE) && Start) begin
            op_q    <= FuncOp;
            mcand_q <= A;
            hi_q    <= '0;
            if (FuncOp == OP_MUL) begin
                acc_q <= B;
                cnt_q <= MulSteps;
            end else begin
                acc_q <= A;
                cnt_q <= {1'b0, shamt};
            end
        end else if (state_q == ST_EXEC) begin
            acc_q <= step_acc;
            hi_q  <= step_hi;
            cnt_q <= cnt_q - CntOne;
        end
    end

    // Later assignments to OFlags take precedence over FlagClr
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            Y       <= '0;
            OFlags  <= '0;
        end else begin
            if (FlagClr) OFlags <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (go_exec) begin
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_DONE;
                            if (one_wr_y) Y <= one_y;
                            OFlags <= one_f;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == CntOne) begin
                        state_q <= ST_DONE;
                        Y       <= step_acc;
                        OFlags  <= make_flags(step_acc, step_c, 1'b0);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = (state_q == ST_DONE);

endmodule
